// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver with a one-entry valid/ack holding register.
module uart_rx_core #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxd,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_overrun,
  output logic       frame_err,
  output logic       busy
);
  localparam int BIT_CNT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_CNT = BIT_CNT / 2;
  localparam int CW = $clog2(BIT_CNT + 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CNT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CNT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shreg, shreg_n;
  logic rxd_m, rxd_s, rxd_p;
  logic tick, commit, ferr;

  assign busy = state != IDLE;
  assign tick = cnt == ((state == START) ? HALF_LAST : BIT_LAST);

  always_comb begin
    state_n = state;
    cnt_n = cnt + CW'(1);
    idx_n = idx;
    shreg_n = shreg;
    commit = 1'b0;
    ferr = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (rxd_p && !rxd_s) state_n = START;
      end
      START: if (tick) begin
        cnt_n = '0;
        idx_n = 3'd0;
        state_n = rxd_s ? IDLE : DATA;
      end
      DATA: if (tick) begin
        cnt_n = '0;
        shreg_n[idx] = rxd_s;
        idx_n = idx + 3'd1;
        state_n = (idx == 3'd7) ? STOP : DATA;
      end
      STOP: if (tick) begin
        cnt_n = '0;
        commit = rxd_s;
        ferr = !rxd_s;
        state_n = rxd_s ? IDLE : BRK;
      end
      BRK: begin
        cnt_n = '0;
        if (rxd_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Synchronizer and edge-detect flops idle high so reset never fakes a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
      rxd_p <= 1'b1;
      state <= IDLE;
      cnt <= '0;
      idx <= 3'd0;
      shreg <= 8'd0;
    end else begin
      rxd_m <= uart_rxd;
      rxd_s <= rxd_m;
      rxd_p <= rxd_s;
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      shreg <= shreg_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data <= 8'd0;
      rx_valid <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= ferr;
      if (commit) begin
        if (!rx_valid || rx_ack) begin
          rx_data <= shreg;
          rx_valid <= 1'b1;
          rx_overrun <= 1'b0;
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ack) begin
        rx_valid <= 1'b0;
        rx_overrun <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed and randomized 8N1 frames checked against a byte-queue model.
module tb_uart_rx_core;
  localparam int HALF = 5;
  logic clk = 1'b0, rst = 1'b1, uart_rxd = 1'b1, man_ack = 1'b0, auto_en = 1'b0, auto_a = 1'b0;
  logic rx_ack;
  logic [7:0] rx_data;
  logic rx_valid, rx_overrun, frame_err, busy;
  int checks = 0, failures = 0, ferr_cnt = 0, run = 0, max_run = 0, g0, f0, ne;
  logic meas = 1'b0, pv = 1'b0, re;
  logic [7:0] rb;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];

  uart_rx_core #(.CLK_FREQ(1000000), .BAUD_RATE(100000)) dut (
    .clk(clk), .rst(rst), .uart_rxd(uart_rxd), .rx_ack(rx_ack),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_overrun(rx_overrun),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;
  assign rx_ack = man_ack | auto_a;
  always @(negedge clk) auto_a = auto_en && rx_valid;

  // A byte is delivered when rx_valid rises or is reloaded under an ack.
  always @(posedge clk) begin
    #1;
    if (rx_valid && (!pv || rx_ack)) got.push_back(rx_data);
    if (frame_err) ferr_cnt++;
    if (!busy) run++;
    else begin
      if (meas && run > max_run) max_run = run;
      run = 0;
    end
    pv = rx_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rxd = f[i];
      idle(10);
    end
  endtask

  task automatic ack_pulse();
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, rx_valid, 0);
    chk({tag, "_data"}, rx_data, 0);
    chk({tag, "_ovr"}, rx_overrun, 0);
    chk({tag, "_ferr"}, frame_err, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    idle(3);
    chk_zero("rst");
    rst = 1'b0;
    idle(5);

    g0 = got.size(); f0 = ferr_cnt;
    send(8'h55, 1'b1);
    idle(20);
    chk("single_count", got.size() - g0, 1);
    chk("single_byte", got[g0], 8'h55);
    chk("single_valid", rx_valid, 1);
    chk("single_data", rx_data, 8'h55);
    chk("single_ferr", ferr_cnt - f0, 0);
    chk("single_ovr", rx_overrun, 0);
    ack_pulse();
    chk("single_ack_valid", rx_valid, 0);
    chk("single_ack_data", rx_data, 8'h55);

    g0 = got.size(); f0 = ferr_cnt; auto_en = 1'b1;
    send(8'hA5, 1'b1);
    meas = 1'b1;
    send(8'h3C, 1'b1);
    send(8'hFF, 1'b1);
    meas = 1'b0;
    idle(20);
    auto_en = 1'b0;
    chk("b2b_count", got.size() - g0, 3);
    chk("b2b_byte0", got[g0], 8'hA5);
    chk("b2b_byte1", got[g0+1], 8'h3C);
    chk("b2b_byte2", got[g0+2], 8'hFF);
    chk("b2b_gap_seen", max_run > 0, 1);
    chk("b2b_gap_max", max_run <= HALF + 3, 1);
    chk("b2b_valid", rx_valid, 0);
    chk("b2b_ferr", ferr_cnt - f0, 0);
    chk("b2b_ovr", rx_overrun, 0);

    g0 = got.size();
    send(8'h12, 1'b1);
    send(8'h34, 1'b1);
    idle(20);
    chk("ovr_count", got.size() - g0, 1);
    chk("ovr_data", rx_data, 8'h12);
    chk("ovr_flag", rx_overrun, 1);
    chk("ovr_valid", rx_valid, 1);
    ack_pulse();
    chk("ovr_ack_valid", rx_valid, 0);
    chk("ovr_ack_flag", rx_overrun, 0);
    send(8'h12, 1'b1);
    fork
      send(8'h34, 1'b1);
      begin
        idle(97);
        ack_pulse();
      end
    join
    idle(20);
    chk("ovr2_data", rx_data, 8'h34);
    chk("ovr2_flag", rx_overrun, 0);
    chk("ovr2_valid", rx_valid, 1);
    ack_pulse();

    g0 = got.size(); f0 = ferr_cnt;
    send(8'h81, 1'b0);
    idle(50);
    uart_rxd = 1'b1;
    idle(20);
    chk("brk_ferr", ferr_cnt - f0, 1);
    chk("brk_valid", rx_valid, 0);
    chk("brk_count", got.size() - g0, 0);
    send(8'h7E, 1'b1);
    idle(20);
    chk("brk_next_count", got.size() - g0, 1);
    chk("brk_next_byte", got[g0], 8'h7E);
    chk("brk_next_ferr", ferr_cnt - f0, 1);
    ack_pulse();

    g0 = got.size(); f0 = ferr_cnt;
    uart_rxd = 1'b0;
    idle(2);
    uart_rxd = 1'b1;
    idle(3);
    chk("glitch_busy_start", busy, 1);
    idle(20);
    chk("glitch_busy_end", busy, 0);
    chk("glitch_count", got.size() - g0, 0);
    chk("glitch_ferr", ferr_cnt - f0, 0);

    g0 = got.size();
    fork
      send(8'hC3, 1'b1);
      begin
        idle(55);
        rst = 1'b1;
        idle(2);
        chk_zero("midrst");
      end
    join
    chk_zero("midrst_hold");
    rst = 1'b0;
    idle(5);
    chk_zero("midrst_rel");
    send(8'h5A, 1'b1);
    idle(20);
    chk("midrst_count", got.size() - g0, 1);
    chk("midrst_byte", got[g0], 8'h5A);
    ack_pulse();

    g0 = got.size(); f0 = ferr_cnt; ne = 0; auto_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      rb = 8'($urandom);
      re = $urandom_range(0, 4) == 0;
      if (re) begin
        send(rb, 1'b0);
        idle(int'($urandom_range(0, 30)));
        uart_rxd = 1'b1;
        ne++;
        idle(5);
      end else begin
        send(rb, 1'b1);
        exp_q.push_back(rb);
      end
      idle(int'($urandom_range(0, 25)));
    end
    idle(30);
    auto_en = 1'b0;
    chk("rnd_count", got.size() - g0, exp_q.size());
    foreach (exp_q[i]) chk("rnd_byte", got[g0+i], exp_q[i]);
    chk("rnd_ferr", ferr_cnt - f0, ne);
    chk("rnd_ovr", rx_overrun, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
